// File: rtl/sn74148_pkg.sv
// Shared constants, FSM state type and priority helper for the SN74148-style encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sn74148_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Index of the highest set bit; callers only use it when vec != 0.
  function automatic logic [CODE_W-1:0] hi_index(input logic [N_REQ-1:0] vec);
    hi_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) hi_index = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/sn_sync.sv
// One-bit multi-flop synchronizer for an asynchronous active-low request line.
// Latency: STAGES clock edges from input sample to output.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low, flops reset to 1 = inactive), d (async in), q (synchronized out).
module sn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sn74148_prio_encoder.sv
// Edge-latched 8:3 priority encoder with valid/ready handoff of the active-low code.
// Latency: request sampled at edge N -> pending at N+2 -> valid at N+3 (SYNC_STAGES=2); max one code per two cycles.
// Backpressure: while valid && !ready, code_b/valid hold; newer edges accumulate in pending (repeats set lost).
// Ports: clk, rst_n, req_b[7:0] (async, active-low, bit 7 highest), en_b (active-low enable),
//        code_b[2:0]/valid/ready (handoff), gs_b (any pending, active-low), lost (sticky dropped edge),
//        eo_b (only when SN74148_CASCADE_EN is defined: low when enabled with nothing pending).
module sn74148_prio_encoder
  import sn74148_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_b,
  input  logic              en_b,
  output logic [CODE_W-1:0] code_b,
  output logic              valid,
  input  logic              ready,
  output logic              gs_b,
  output logic              lost
`ifdef SN74148_CASCADE_EN
  ,
  output logic              eo_b
`endif
);

  logic [N_REQ-1:0]  req_s;
  logic [N_REQ-1:0]  req_s_prev_q, req_s_prev_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              lost_q, lost_d;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_b_q, code_b_d;
  logic              valid_q, valid_d;

  logic [N_REQ-1:0]  fall;
  logic [N_REQ-1:0]  clr_mask;
  logic              hs;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    sn_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_b[g]),
      .q     (req_s[g])
    );
  end

  assign hs   = valid_q & ready;
  assign fall = req_s_prev_q & ~req_s;

  // Set beats clear: an edge on the bit being handed off re-arms it, and
  // that is not a lost edge because the old one was just consumed.
  always_comb begin
    clr_mask = '0;
    if (hs) clr_mask[~code_b_q] = 1'b1;
    req_s_prev_d = req_s;
    pending_d    = fall | (pending_q & ~clr_mask);
    lost_d       = lost_q | (|(fall & pending_q & ~clr_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s_prev_q <= '1;
      pending_q    <= '0;
      lost_q       <= 1'b0;
    end else begin
      req_s_prev_q <= req_s_prev_d;
      pending_q    <= pending_d;
      lost_q       <= lost_d;
    end
  end

  // Enable only gates the IDLE->PRESENT launch; an open transaction always completes.
  always_comb begin
    state_d  = state_q;
    code_b_d = code_b_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (!en_b && (pending_q != '0)) begin
          state_d  = ST_PRESENT;
          code_b_d = ~hi_index(pending_q);
          valid_d  = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_b_q <= '1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_b_q <= code_b_d;
      valid_q  <= valid_d;
    end
  end

  assign code_b = code_b_q;
  assign valid  = valid_q;
  assign lost   = lost_q;
  assign gs_b   = ~|pending_q;

`ifdef SN74148_CASCADE_EN
  assign eo_b = en_b | (|pending_q);
`endif

endmodule

// File: tb/tb_sn74148_prio_encoder.sv
module tb_sn74148_prio_encoder;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_b = 8'hFF;
  logic       en_b = 1'b0;
  logic       ready = 1'b0;
  logic [2:0] code_b;
  logic       valid;
  logic       gs_b;
  logic       lost;
`ifdef SN74148_CASCADE_EN
  logic       eo_b;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: requests seen as a sample history, pending as a bit set,
  // the presented request as an integer index.
  logic [7:0] hist [0:S];
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_idx;
  logic       m_lost;

  sn74148_prio_encoder #(.SYNC_STAGES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_b  (req_b),
    .en_b   (en_b),
    .code_b (code_b),
    .valid  (valid),
    .ready  (ready),
    .gs_b   (gs_b),
    .lost   (lost)
`ifdef SN74148_CASCADE_EN
    ,
    .eo_b   (eo_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_code();
    logic [2:0] v;
    v = 3'(m_idx);
    return ~v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= S; j++) hist[j] = 8'hFF;
    m_pend  = 8'h00;
    m_valid = 1'b0;
    m_idx   = 0;
    m_lost  = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge,
  // then returns at the falling edge where outputs are observed.
  task automatic tick();
    logic [7:0] fall;
    logic [7:0] old_pend;
    logic       handoff;
    int         top;
    @(posedge clk);
    old_pend = m_pend;
    handoff  = m_valid && ready;
    fall     = hist[S] & ~hist[S-1];
    for (int i = 0; i < 8; i++) begin
      if (fall[i]) begin
        if (old_pend[i] && !(handoff && m_idx == i)) m_lost = 1'b1;
        m_pend[i] = 1'b1;
      end else if (handoff && m_idx == i) begin
        m_pend[i] = 1'b0;
      end
    end
    if (m_valid) begin
      if (ready) m_valid = 1'b0;
    end else if (!en_b && old_pend != 8'h00) begin
      top = 0;
      for (int i = 0; i < 8; i++) if (old_pend[i]) top = i;
      m_idx   = top;
      m_valid = 1'b1;
    end
    for (int j = S; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = req_b;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_b = 8'hFF;
    en_b  = 1'b0;
    ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (code_b !== 3'b111) begin bad++; $display("FAIL reset_code got=%b want=111", code_b); end
    total++; if (gs_b !== 1'b1) begin bad++; $display("FAIL reset_gs got=%b want=1", gs_b); end
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b want=0", lost); end
  endtask

  task automatic test_single();
    apply_reset();
    ready = 1'b1;
    req_b = 8'hFB;
    tick(); tick(); tick();
    total++; if (valid !== 1'b0 || gs_b !== 1'b0) begin bad++; $display("FAIL single_n2 valid=%b gs_b=%b want 0/0", valid, gs_b); end
    tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b101) begin bad++; $display("FAIL single_n3 valid=%b code_b=%b want 1/101", valid, code_b); end
    tick();
    total++; if (valid !== 1'b0 || gs_b !== 1'b1) begin bad++; $display("FAIL single_n4 valid=%b gs_b=%b want 0/1", valid, gs_b); end
    req_b = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_priority();
    apply_reset();
    ready = 1'b1;
    req_b = 8'hBD;
    repeat (4) tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b001) begin bad++; $display("FAIL prio_first valid=%b code_b=%b want 1/001", valid, code_b); end
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL prio_gap valid=%b want 0", valid); end
    tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b110) begin bad++; $display("FAIL prio_second valid=%b code_b=%b want 1/110", valid, code_b); end
    tick();
    total++; if (valid !== 1'b0 || gs_b !== 1'b1) begin bad++; $display("FAIL prio_done valid=%b gs_b=%b want 0/1", valid, gs_b); end
    req_b = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int held_bad;
    apply_reset();
    ready = 1'b0;
    req_b = 8'hFB;
    repeat (4) tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b101) begin bad++; $display("FAIL bp_first valid=%b code_b=%b want 1/101", valid, code_b); end
    req_b = 8'h7B;
    held_bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid !== 1'b1 || code_b !== 3'b101) held_bad++;
    end
    total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold cycles_changed=%0d want 0", held_bad); end
    ready = 1'b1;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b want 0", valid); end
    tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b000) begin bad++; $display("FAIL bp_bit7 valid=%b code_b=%b want 1/000", valid, code_b); end
    tick();
    total++; if (valid !== 1'b0 || lost !== 1'b0) begin bad++; $display("FAIL bp_end valid=%b lost=%b want 0/0", valid, lost); end
    req_b = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_double_edge();
    int codes;
    apply_reset();
    ready = 1'b0;
    req_b = 8'hF7;
    repeat (4) tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b100) begin bad++; $display("FAIL dbl_first valid=%b code_b=%b want 1/100", valid, code_b); end
    req_b = 8'hFF;
    repeat (3) tick();
    req_b = 8'hF7;
    repeat (4) tick();
    total++; if (lost !== 1'b1) begin bad++; $display("FAIL dbl_lost got=%b want=1", lost); end
    ready = 1'b1;
    codes = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid === 1'b1) codes++;
    end
    total++; if (codes != 0 || gs_b !== 1'b1) begin bad++; $display("FAIL dbl_once extra_codes=%0d gs_b=%b want 0/1", codes, gs_b); end
    total++; if (lost !== 1'b1) begin bad++; $display("FAIL dbl_sticky got=%b want=1", lost); end
    req_b = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_enable();
    apply_reset();
    en_b  = 1'b1;
    ready = 1'b0;
    req_b = 8'hEF;
    repeat (6) tick();
    total++; if (valid !== 1'b0 || gs_b !== 1'b0) begin bad++; $display("FAIL en_hold valid=%b gs_b=%b want 0/0", valid, gs_b); end
    en_b = 1'b0;
    tick();
    total++; if (valid !== 1'b1 || code_b !== 3'b011) begin bad++; $display("FAIL en_go valid=%b code_b=%b want 1/011", valid, code_b); end
    en_b  = 1'b1;
    ready = 1'b1;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL en_complete valid=%b want 0", valid); end
    req_b = 8'hFF;
    repeat (4) tick();
    en_b = 1'b0;
  endtask

`ifdef SN74148_CASCADE_EN
  task automatic test_cascade();
    apply_reset();
    en_b  = 1'b0;
    req_b = 8'hFF;
    tick();
    total++; if (eo_b !== 1'b0) begin bad++; $display("FAIL casc_idle eo_b=%b want 0", eo_b); end
    en_b = 1'b1;
    #1;
    total++; if (eo_b !== 1'b1) begin bad++; $display("FAIL casc_dis eo_b=%b want 1", eo_b); end
    repeat (3) tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL casc_novalid valid=%b want 0", valid); end
    en_b = 1'b0;
  endtask
`endif

  task automatic test_random();
    int e_valid, e_code, e_gs, e_lost, e_eo;
    apply_reset();
    e_valid = 0; e_code = 0; e_gs = 0; e_lost = 0; e_eo = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) req_b[b] = ~req_b[b];
      en_b  = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 2) != 0);
      tick();
      if (valid !== m_valid) e_valid++;
      if (code_b !== exp_code()) e_code++;
      if (gs_b !== (m_pend == 8'h00)) e_gs++;
      if (lost !== m_lost) e_lost++;
`ifdef SN74148_CASCADE_EN
      if (eo_b !== (en_b || m_pend != 8'h00)) e_eo++;
`endif
    end
    total++; if (e_valid != 0) begin bad++; $display("FAIL rand_valid mismatched_cycles=%0d want 0", e_valid); end
    total++; if (e_code != 0) begin bad++; $display("FAIL rand_code mismatched_cycles=%0d want 0", e_code); end
    total++; if (e_gs != 0) begin bad++; $display("FAIL rand_gs mismatched_cycles=%0d want 0", e_gs); end
    total++; if (e_lost != 0) begin bad++; $display("FAIL rand_lost mismatched_cycles=%0d want 0", e_lost); end
    total++; if (e_eo != 0) begin bad++; $display("FAIL rand_eo mismatched_cycles=%0d want 0", e_eo); end
  endtask

  task automatic test_reset_mid_present();
    apply_reset();
    ready = 1'b0;
    req_b = 8'h5F;
    repeat (4) tick();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL midrst_pre valid=%b want 1", valid); end
    req_b = 8'hFF;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (valid !== 1'b0 || code_b !== 3'b111 || gs_b !== 1'b1) begin bad++; $display("FAIL midrst_async valid=%b code_b=%b gs_b=%b want 0/111/1", valid, code_b, gs_b); end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) tick();
    total++; if (valid !== 1'b0 || gs_b !== 1'b1) begin bad++; $display("FAIL midrst_after valid=%b gs_b=%b want 0/1", valid, gs_b); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_double_edge();
    test_enable();
`ifdef SN74148_CASCADE_EN
    test_cascade();
`endif
    test_reset_mid_present();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn74148_prio_encoder.md
SN74148_PRIO_ENCODER -- requirements
Module: sn74148_prio_encoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per request line (legal values 2..4).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low; polarity and synchronicity are fixed.
REQ-004 SHALL have port req_b  input  8  active-low asynchronous request lines; index 7 is highest priority.
REQ-005 SHALL have port en_b  input  1  active-low encode enable, synchronous.
REQ-006 SHALL have port code_b  output  3  active-low index of the presented request.
REQ-007 SHALL have port valid  output  1  code_b is held stable and presented.
REQ-008 SHALL have port ready  input  1  consumer accepts code_b when valid=1 and ready=1.
REQ-009 SHALL have port gs_b  output  1  active-low group select, asserted when any pending bit is set.
REQ-010 SHALL have port lost  output  1  sticky flag: a request edge was dropped.

Function
REQ-011 Each req_b bit SHALL pass through SYNC_STAGES flops; each flop resets to 1 (inactive).
REQ-012 A 1->0 transition of a synchronized bit SHALL set pending[i] on the next edge; pending is edge-latched, not level-sensitive.
REQ-013 Latency with SYNC_STAGES=2: req_b[i] is first sampled low at edge N; pending[i] is set at N+2; valid rises at N+3 if the FSM is IDLE.
REQ-014 FSM SHALL have states IDLE and PRESENT only.
REQ-015 IDLE -> PRESENT when en_b=0 and pending!=0: code_b loads ~(highest set index), valid<=1.
REQ-016 PRESENT: code_b and valid SHALL hold; on valid&ready, pending[code] clears, the FSM returns to IDLE, and valid=0 from the next cycle.
REQ-017 The maximum code rate SHALL be one per two cycles.
REQ-018 A new edge on a bit already pending SHALL not be counted; it SHALL set lost.
REQ-019 An edge on the presented bit in the same cycle as its handshake: set wins, pending stays 1, lost is not set.
REQ-020 Raising en_b during PRESENT SHALL NOT abort; the transaction completes, then the FSM stays IDLE.
REQ-021 Higher-priority pending arriving during PRESENT SHALL NOT change code_b; it is taken on the next IDLE->PRESENT transition.
REQ-022 gs_b = ~|pending, combinational from the pending register.

Reset
REQ-023 rst_n=0 SHALL asynchronously set: synchronizers to all 1, pending=0, state=IDLE, valid=0, code_b=3'b111, lost=0, so gs_b=1.
REQ-024 Reset mid-PRESENT SHALL discard the presented code and all pending without handshake.
REQ-025 lost SHALL be cleared only by reset.

Configuration
REQ-026 Macro SN74148_CASCADE_EN defined: the block SHALL add output eo_b (1 bit), low when en_b=0 and pending=0, for chaining into a lower-priority device's en_b.
REQ-027 Macro SN74148_CASCADE_EN undefined: eo_b and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package sn74148_pkg SHALL hold N_REQ=8, CODE_W=3, and the FSM state enum.
REQ-029 Synchronizer SHALL be sub-module sn_sync (one bit, SYNC_STAGES deep, reset value 1), instantiated 8 times.

Verification
REQ-030 Reset scenario: rst_n low, then high -> valid=0, code_b=3'b111, gs_b=1, lost=0.
REQ-031 Single request: req_b=8'hFB (bit 2) sampled at edge N, ready=1 -> valid at N+3 with code_b=3'b101; valid=0 at N+4; gs_b=1 afterwards.
REQ-032 Priority: bits 1 and 6 fall together, ready=1 -> codes 6 then 1 (code_b 3'b001 then 3'b110) in consecutive handshakes; pending=0 afterwards.
REQ-033 Backpressure: ready=0 for 10 cycles while bit 7 also falls -> code_b held at the first code, no change until the handshake; bit 7 presented next.
REQ-034 Double edge: bit 3 toggles 0->1->0 before handshake -> one code 3'b100 only, lost=1.
REQ-035 Cascade (SN74148_CASCADE_EN defined): en_b=0, req_b=8'hFF -> eo_b=0; en_b=1 -> eo_b=1, no valid.
